// File: rtl/pixel_seq_pkg.sv
// Shared definitions for the pixel timing sequencer: configuration opcodes,
// FSM state encoding and the field layout of the 16-bit configuration word.
package pixel_seq_pkg;

  localparam logic [3:0] OP_SEL         = 4'd0;
  localparam logic [3:0] OP_PTR         = 4'd1;
  localparam logic [3:0] OP_RISE        = 4'd2;
  localparam logic [3:0] OP_FALL        = 4'd3;
  localparam logic [3:0] OP_IDLE        = 4'd4;
  localparam logic [3:0] OP_MEAS        = 4'd5;
  localparam logic [3:0] OP_BURST       = 4'd6;
  localparam logic [3:0] OP_ARM         = 4'd7;
  localparam logic [3:0] OP_TRIG        = 4'd8;
  localparam logic [3:0] OP_CLR_MISSED  = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int CFG_W   = 16;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 12;
  localparam int DATA_HI = 11;
  localparam int DATA_LO = 0;

  function automatic logic [3:0] cfg_opcode(input logic [CFG_W-1:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

  function automatic logic [11:0] cfg_payload(input logic [CFG_W-1:0] word);
    return word[DATA_HI:DATA_LO];
  endfunction

endpackage

// File: rtl/pixel_timing_sequencer_if.sv
// Bus between the SPI command decoder / DIO pins and the pixel timing
// sequencer. The sequencer uses the slave modport.
interface pixel_timing_sequencer_if #(
  parameter int NUM_CH = 8,
  parameter int SEL_W  = 4
);
  logic              cfg_write;
  logic [15:0]       cfg_word;
  logic              trig_in;
  logic [NUM_CH-1:0] ch_out;
  logic [SEL_W-1:0]  sel_out;
  logic              ready;
  logic              measure_flag;
  logic [15:0]       run_count;
  logic [7:0]        missed_cnt;

  modport master (
    output cfg_write, cfg_word, trig_in,
    input  ch_out, sel_out, ready, measure_flag, run_count, missed_cnt
  );

  modport slave (
    input  cfg_write, cfg_word, trig_in,
    output ch_out, sel_out, ready, measure_flag, run_count, missed_cnt
  );
endinterface

// File: rtl/trig_sync_edge.sv
// Two-flop synchroniser for an asynchronous DIO input followed by a
// rising-edge detector producing a one-cycle pulse.
module trig_sync_edge (
  input  logic clk,
  input  logic res_n,
  input  logic din,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic sync_prev;

  // Synchroniser chain plus one delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (!res_n) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync1     <= din;
      sync2     <= sync1;
      sync_prev <= sync2;
    end
  end

  assign pulse = sync2 & ~sync_prev;

endmodule

// File: rtl/pixel_timing_sequencer.sv
// Pixel timing sequencer: NUM_CH programmable pulse channels plus a SEL bus,
// burst runs per trigger, arming, and shadowed configuration that is copied
// to the active set when a trigger is accepted.
// Optional: define PIXEL_SEQ_MISSED_TRIG_CNT_EN to count ignored triggers.
module pixel_timing_sequencer
  import pixel_seq_pkg::*;
#(
  parameter int NUM_CH  = 8,
  parameter int TIME_W  = 10,
  parameter int SEL_W   = 4,
  parameter int BURST_W = 8
) (
  input logic                      clk,
  input logic                      res_n,
  pixel_timing_sequencer_if.slave  bus
);

  localparam logic [BURST_W-1:0] BURST_ONE = BURST_W'(1);

  logic [3:0]  opcode;
  logic [11:0] cfg_data;
  logic        unused_cfg;

  assign opcode     = cfg_opcode(bus.cfg_word);
  assign cfg_data   = cfg_payload(bus.cfg_word);
  assign unused_cfg = ^bus.cfg_word;

  // Shadow configuration
  logic [SEL_W-1:0]   sel_sh;
  logic [3:0]         ptr;
  logic [TIME_W-1:0]  rise_sh [NUM_CH];
  logic [TIME_W-1:0]  fall_sh [NUM_CH];
  logic [NUM_CH-1:0]  idle_sh;
  logic [TIME_W-1:0]  meas_sh;
  logic [BURST_W-1:0] burst_sh;
  logic               armed;

  // Active configuration
  logic [TIME_W-1:0]  rise_act [NUM_CH];
  logic [TIME_W-1:0]  fall_act [NUM_CH];
  logic [NUM_CH-1:0]  idle_act;
  logic [TIME_W-1:0]  meas_act;
  logic [SEL_W-1:0]   sel_q;

  // Run control
  state_t             state_q, state_d;
  logic [TIME_W-1:0]  t_q, t_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               run_done;
  logic [15:0]        run_count_q;
  logic [NUM_CH-1:0]  ch_q, ch_d;

  logic pin_pulse;
  logic soft_trig;
  logic trig_any;
  logic accept;

  trig_sync_edge u_trig (
    .clk   (clk),
    .res_n (res_n),
    .din   (bus.trig_in),
    .pulse (pin_pulse)
  );

  assign soft_trig = bus.cfg_write && (opcode == OP_TRIG);
  assign trig_any  = pin_pulse | soft_trig;
  assign accept    = trig_any && (state_q == ST_IDLE) && armed;

  // Configuration writes land in the shadow set at any time
  always_ff @(posedge clk) begin
    if (!res_n) begin
      sel_sh   <= '0;
      ptr      <= '0;
      idle_sh  <= '0;
      meas_sh  <= '0;
      burst_sh <= BURST_ONE;
      armed    <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        rise_sh[i] <= '0;
        fall_sh[i] <= '0;
      end
    end else if (bus.cfg_write) begin
      case (opcode)
        OP_SEL:  sel_sh <= cfg_data[SEL_W-1:0];
        OP_PTR:  ptr    <= cfg_data[3:0];
        OP_RISE: begin
          for (int i = 0; i < NUM_CH; i++)
            if (int'(ptr) == i) rise_sh[i] <= cfg_data[TIME_W-1:0];
        end
        OP_FALL: begin
          for (int i = 0; i < NUM_CH; i++)
            if (int'(ptr) == i) fall_sh[i] <= cfg_data[TIME_W-1:0];
        end
        OP_IDLE: begin
          for (int i = 0; i < NUM_CH; i++)
            if (int'(ptr) == i) idle_sh[i] <= cfg_data[0];
        end
        OP_MEAS:  meas_sh  <= cfg_data[TIME_W-1:0];
        OP_BURST: burst_sh <= (cfg_data[BURST_W-1:0] == '0) ? BURST_ONE
                                                             : cfg_data[BURST_W-1:0];
        OP_ARM:   armed    <= cfg_data[0];
        default:  ;
      endcase
    end
  end

  // Snapshot shadow into active set (and SEL onto the pins) on acceptance
  always_ff @(posedge clk) begin
    if (!res_n) begin
      idle_act <= '0;
      meas_act <= '0;
      sel_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        rise_act[i] <= '0;
        fall_act[i] <= '0;
      end
    end else if (accept) begin
      rise_act <= rise_sh;
      fall_act <= fall_sh;
      idle_act <= idle_sh;
      meas_act <= meas_sh;
      sel_q    <= sel_sh;
    end
  end

  // Next-state, run counter, burst bookkeeping and channel levels
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    burst_d  = burst_q;
    run_done = 1'b0;
    ch_d     = idle_act;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_RUN;
          t_d     = '0;
          burst_d = burst_sh;
        end
      end
      ST_RUN: begin
        if (t_q == meas_act) begin
          run_done = 1'b1;
          t_d      = '0;
          if (burst_q > BURST_ONE) burst_d = burst_q - BURST_ONE;
          else                     state_d = ST_IDLE;
        end else begin
          t_d = t_q + TIME_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The first RUN cycle already shows the idle level being loaded
    for (int i = 0; i < NUM_CH; i++) begin
      if (state_q == ST_RUN)
        ch_d[i] = idle_act[i] ^ ((t_q >= rise_act[i]) && (t_q < fall_act[i]));
      else
        ch_d[i] = accept ? idle_sh[i] : idle_act[i];
    end
  end

  // State and run registers
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      burst_q     <= BURST_ONE;
      run_count_q <= '0;
      ch_q        <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      burst_q <= burst_d;
      ch_q    <= ch_d;
      if (run_done) run_count_q <= run_count_q + 16'd1;
    end
  end

`ifdef PIXEL_SEQ_MISSED_TRIG_CNT_EN
  logic       missed_evt;
  logic [7:0] missed_q;

  assign missed_evt = trig_any && !accept;

  // Saturating count of ignored triggers, cleared by opcode 9
  always_ff @(posedge clk) begin
    if (!res_n)
      missed_q <= '0;
    else if (bus.cfg_write && (opcode == OP_CLR_MISSED))
      missed_q <= '0;
    else if (missed_evt && (missed_q != 8'hFF))
      missed_q <= missed_q + 8'd1;
  end

  assign bus.missed_cnt = missed_q;
`else
  assign bus.missed_cnt = '0;
`endif

  assign bus.ch_out       = ch_q;
  assign bus.sel_out      = sel_q;
  assign bus.ready        = (state_q == ST_IDLE) && armed;
  assign bus.measure_flag = (state_q == ST_RUN);
  assign bus.run_count    = run_count_q;

endmodule

// File: tb/tb_pixel_timing_sequencer.sv
// Directed bench for pixel_timing_sequencer (NUM_CH=8, TIME_W=10, SEL_W=4).
module tb_pixel_timing_sequencer;
  import pixel_seq_pkg::*;

  logic clk = 1'b0;
  logic res_n;
  int   checks = 0;
  int   failures = 0;
  int   len;
  logic [31:0] pat;

`ifdef PIXEL_SEQ_MISSED_TRIG_CNT_EN
  localparam int MISSED_EXP = 2;
`else
  localparam int MISSED_EXP = 0;
`endif

  pixel_timing_sequencer_if #(.NUM_CH(8), .SEL_W(4)) bus ();

  pixel_timing_sequencer #(
    .NUM_CH(8), .TIME_W(10), .SEL_W(4), .BURST_W(8)
  ) dut (
    .clk   (clk),
    .res_n (res_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] op, input logic [11:0] d);
    bus.cfg_write = 1'b1;
    bus.cfg_word  = {op, d};
    tick();
    bus.cfg_write = 1'b0;
    bus.cfg_word  = '0;
  endtask

  task automatic pin_trig();
    bus.trig_in = 1'b1;
    tick();
    tick();
    bus.trig_in = 1'b0;
  endtask

  task automatic wait_run(input string tag, input int budget);
    int n = 0;
    while (bus.measure_flag !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, bus.measure_flag, 1);
  endtask

  // Records ch_out[ch] from now while measure_flag is high, plus one
  // sample after the run ends; len counts the RUN samples.
  task automatic capture(input int ch, output int n, output logic [31:0] p);
    n = 0;
    p = '0;
    while (bus.measure_flag === 1'b1 && n < 31) begin
      p[n] = bus.ch_out[ch];
      n++;
      tick();
    end
    p[n] = bus.ch_out[ch];
  endtask

  initial begin
    res_n         = 1'b0;
    bus.cfg_write = 1'b0;
    bus.cfg_word  = '0;
    bus.trig_in   = 1'b0;
    tick(); tick(); tick();
    res_n = 1'b1;
    tick();

    // Reset state
    check("rst_ch_out", bus.ch_out, 0);
    check("rst_sel_out", bus.sel_out, 0);
    check("rst_ready", bus.ready, 0);
    check("rst_measure", bus.measure_flag, 0);
    check("rst_run_count", bus.run_count, 0);
    check("rst_missed", bus.missed_cnt, 0);

    // Single run from the pin: ch0 rise 2 fall 5, MEAS_T 9
    wr(OP_ARM, 12'd1);
    check("armed_ready", bus.ready, 1);
    wr(OP_PTR, 12'd0);
    wr(OP_RISE, 12'd2);
    wr(OP_FALL, 12'd5);
    wr(OP_MEAS, 12'd9);
    bus.trig_in = 1'b1;
    tick();
    check("lat_edge1", bus.measure_flag, 0);
    tick();
    bus.trig_in = 1'b0;
    check("lat_edge2", bus.measure_flag, 0);
    tick();
    check("lat_edge3", bus.measure_flag, 1);
    capture(0, len, pat);
    check("t1_len", len, 10);
    check("t1_ch0", pat, 32'h038);
    check("t1_run_count", bus.run_count, 1);
    check("t1_ready", bus.ready, 1);

    // Burst of 3, ch3 idle high with rise==fall
    wr(OP_PTR, 12'd3);
    wr(OP_IDLE, 12'd1);
    wr(OP_RISE, 12'd4);
    wr(OP_FALL, 12'd4);
    wr(OP_BURST, 12'd3);
    wr(OP_MEAS, 12'd4);
    wr(OP_TRIG, 12'd0);
    check("t2_start", bus.measure_flag, 1);
    capture(3, len, pat);
    check("t2_len", len, 15);
    check("t2_ch3", pat, 32'hFFFF);
    check("t2_run_count", bus.run_count, 4);
    check("t2_ready", bus.ready, 1);

    // Shadow writes during a run take effect on the next trigger only
    wr(OP_BURST, 12'd1);
    wr(OP_MEAS, 12'd9);
    wr(OP_PTR, 12'd0);
    wr(OP_TRIG, 12'd0);
    check("t3_start", bus.measure_flag, 1);
    wr(OP_RISE, 12'd7);
    wr(OP_FALL, 12'd9);
    wr(OP_SEL, 12'd5);
    check("t3_sel_old", bus.sel_out, 0);
    capture(0, len, pat);
    check("t3_len_a", len, 7);
    check("t3_ch0_a", pat, 32'h07);
    check("t3_run_count_a", bus.run_count, 5);
    wr(OP_TRIG, 12'd0);
    check("t3_sel_new", bus.sel_out, 5);
    capture(0, len, pat);
    check("t3_len_b", len, 10);
    check("t3_ch0_b", pat, 32'h300);
    check("t3_run_count_b", bus.run_count, 6);

    // Disarmed trigger, trigger mid-run, disarm mid-run
    wr(OP_ARM, 12'd0);
    check("t4_ready_disarmed", bus.ready, 0);
    wr(OP_TRIG, 12'd0);
    check("t4_ignored_disarmed", bus.measure_flag, 0);
    wr(OP_ARM, 12'd1);
    pin_trig();
    wait_run("t4_start", 5);
    wr(OP_TRIG, 12'd0);
    wr(OP_ARM, 12'd0);
    capture(0, len, pat);
    check("t4_len", len, 8);
    check("t4_ch0", pat, 32'hC0);
    check("t4_run_count", bus.run_count, 7);
    check("t4_ready_after", bus.ready, 0);
    check("t4_missed", bus.missed_cnt, MISSED_EXP);
    wr(OP_CLR_MISSED, 12'd0);
    check("t4_missed_clr", bus.missed_cnt, 0);
    wr(OP_ARM, 12'd1);

    // Out-of-range pointer write must not touch any channel
    wr(OP_PTR, 12'd4);
    wr(OP_FALL, 12'd6);
    wr(OP_PTR, 12'd12);
    wr(OP_RISE, 12'd3);
    wr(OP_TRIG, 12'd0);
    capture(4, len, pat);
    check("t5_len", len, 10);
    check("t5_ch4", pat, 32'h07E);
    check("t5_run_count", bus.run_count, 8);

    // Reset in the middle of a burst
    wr(OP_BURST, 12'd3);
    wr(OP_TRIG, 12'd0);
    tick(); tick(); tick();
    check("t6_pre_ch4", bus.ch_out[4], 1);
    check("t6_pre_measure", bus.measure_flag, 1);
    res_n = 1'b0;
    tick();
    check("t6_ch_out", bus.ch_out, 0);
    check("t6_sel_out", bus.sel_out, 0);
    check("t6_ready", bus.ready, 0);
    check("t6_measure", bus.measure_flag, 0);
    check("t6_run_count", bus.run_count, 0);
    check("t6_missed", bus.missed_cnt, 0);
    res_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
